// File: rtl/memory_controller_if.sv
// memory_controller_if: request/response handshake plus the word-cell bus (RW, select, i, o).
interface memory_controller_if #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_rw;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [DATA_W-1:0]    resp_rdata;
    logic                 resp_err;
    logic                 RW;
    logic [NUM_WORDS-1:0] select;
    logic [DATA_W-1:0]    i;
    logic [DATA_W-1:0]    o;
    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, resp_ready, o,
        output req_ready, resp_valid, resp_rdata, resp_err, RW, select, i
    );
    modport master (
        output req_valid, req_rw, req_addr, req_wdata, resp_ready, o,
        input  req_ready, resp_valid, resp_rdata, resp_err, RW, select, i
    );
endinterface

// File: rtl/memory_controller.sv
// memory_controller: single-outstanding request sequencer driving one-hot word cells (IDLE/SETUP/ACCESS/RESP).
// Optional access statistics (rd_count/wr_count) under MEMORY_CONTROLLER_STATS_EN.
module memory_controller #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int NUM_WORDS = 16
) (
    input logic clk,
    input logic rst,
    memory_controller_if.slave bus
`ifdef MEMORY_CONTROLLER_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_n;
    logic rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic in_range;
    assign in_range = 32'(addr_q) < 32'(NUM_WORDS);
    assign bus.req_ready = state == IDLE;
    assign bus.resp_valid = state == RESP;
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.req_valid ? SETUP : IDLE;
            SETUP:   state_n = ACCESS;
            ACCESS:  state_n = RESP;
            RESP:    state_n = bus.resp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    // Cell strobes are all registered; select is only raised one cycle after RW/i settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rw_q           <= 1'b0;
            addr_q         <= '0;
            bus.RW         <= 1'b0;
            bus.i          <= '0;
            bus.select     <= '0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                rw_q           <= bus.req_rw;
                addr_q         <= bus.req_addr;
                bus.RW         <= bus.req_rw;
                bus.i          <= bus.req_wdata;
                bus.resp_rdata <= '0;
                bus.resp_err   <= 1'b0;
            end
            if (state == SETUP)
                bus.select <= in_range ? NUM_WORDS'(1) << addr_q : '0;
            if (state == ACCESS) begin
                bus.select     <= '0;
                bus.RW         <= 1'b0;
                bus.resp_err   <= !in_range;
                bus.resp_rdata <= (rw_q || !in_range) ? '0 : bus.o;
            end
        end
    end
`ifdef MEMORY_CONTROLLER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == RESP && bus.resp_ready && !bus.resp_err) begin
            if (rw_q && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            if (!rw_q && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: directed and random requests checked cycle-by-cycle against a word-array reference.
module tb_memory_controller;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NW = 10;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fill = 1'b0;
    int cyc = 0;
    int vectors = 0;
    int errs = 0;
    int acc_cyc = 0;
    int prev_acc = 0;
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] cells [NW];
    int rd_exp = 0;
    int wr_exp = 0;
    memory_controller_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW)) bus ();
`ifdef MEMORY_CONTROLLER_STATS_EN
    logic [15:0] rd_count, wr_count;
    memory_controller #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .rd_count(rd_count), .wr_count(wr_count));
`else
    memory_controller #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Word cells: read mux on select, commit at the edge closing ACCESS unless reset aborts it.
    always_comb begin
        bus.o = '0;
        for (int k = 0; k < NW; k++) if (bus.select[k]) bus.o = cells[k];
    end
    always @(posedge clk) begin
        if (fill) for (int k = 0; k < NW; k++) cells[k] <= DW'(k * 17 + 3);
        else if (!rst && bus.RW) for (int k = 0; k < NW; k++) if (bus.select[k]) cells[k] <= bus.i;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic check_resp(input logic [DW-1:0] erd, input logic eerr);
        check("resp_valid", 32'(bus.resp_valid), 1);
        check("resp_rdata", 32'(bus.resp_rdata), 32'(erd));
        check("resp_err", 32'(bus.resp_err), 32'(eerr));
        check("resp_sel", 32'(bus.select), 0);
        check("resp_rw", 32'(bus.RW), 0);
        check("resp_ready", 32'(bus.req_ready), 0);
    endtask
    task automatic run(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int stall, input logic keep);
        logic in_r;
        logic [NW-1:0] esel;
        logic [DW-1:0] erd;
        in_r = 32'(a) < NW;
        esel = in_r ? NW'(1) << a : '0;
        erd = (rw || !in_r) ? '0 : ref_mem[a];
        check("idle_ready", 32'(bus.req_ready), 1);
        check("idle_sel", 32'(bus.select), 0);
        bus.req_valid = 1'b1;
        bus.req_rw = rw;
        bus.req_addr = a;
        bus.req_wdata = d;
        bus.resp_ready = stall == 0;
        step();
        acc_cyc = cyc;
        if (!keep) bus.req_valid = 1'b0;
        check("setup_ready", 32'(bus.req_ready), 0);
        check("setup_sel", 32'(bus.select), 0);
        check("setup_rw", 32'(bus.RW), 32'(rw));
        check("setup_valid", 32'(bus.resp_valid), 0);
        if (rw) check("setup_i", 32'(bus.i), 32'(d));
        step();
        check("access_sel", 32'(bus.select), 32'(esel));
        check("access_rw", 32'(bus.RW), 32'(rw));
        check("access_valid", 32'(bus.resp_valid), 0);
        step();
        for (int s = 0; s < stall; s++) begin
            check_resp(erd, !in_r);
            step();
        end
        bus.resp_ready = 1'b1;
        check_resp(erd, !in_r);
        step();
        check("done_valid", 32'(bus.resp_valid), 0);
        check("done_ready", 32'(bus.req_ready), 1);
        if (!keep) bus.resp_ready = 1'b0;
        if (in_r && rw) ref_mem[a] = d;
        if (in_r && rw) wr_exp++;
        if (in_r && !rw) rd_exp++;
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_rw = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.resp_ready = 1'b0;
        for (int k = 0; k < 16; k++) ref_mem[k] = DW'(k * 17 + 3);
        fill = 1'b1;
        step();
        fill = 1'b0;
        step();
        check("rst_ready", 32'(bus.req_ready), 1);
        check("rst_valid", 32'(bus.resp_valid), 0);
        check("rst_rdata", 32'(bus.resp_rdata), 0);
        check("rst_err", 32'(bus.resp_err), 0);
        check("rst_rw", 32'(bus.RW), 0);
        check("rst_sel", 32'(bus.select), 0);
        check("rst_i", 32'(bus.i), 0);
        rst = 1'b0;
        step();
        run(1'b1, 4'd3, 8'h09, 0, 1'b0);
        run(1'b0, 4'd3, 8'h00, 0, 1'b0);
        run(1'b0, 4'd3, 8'h00, 5, 1'b0);
        run(1'b0, 4'd12, 8'h00, 0, 1'b0);
        run(1'b1, 4'd15, 8'h77, 1, 1'b0);
        run(1'b0, 4'd9, 8'h00, 0, 1'b0);
        run(1'b1, 4'd5, 8'hA5, 0, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_rw = 1'b1;
        bus.req_addr = 4'd5;
        bus.req_wdata = 8'h5A;
        step();
        bus.req_valid = 1'b0;
        step();
        check("abort_access_sel", 32'(bus.select), 32'h020);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_exp = 0;
        wr_exp = 0;
        check("abort_sel", 32'(bus.select), 0);
        check("abort_ready", 32'(bus.req_ready), 1);
        check("abort_valid", 32'(bus.resp_valid), 0);
        check("abort_rw", 32'(bus.RW), 0);
        step();
        check("abort_valid2", 32'(bus.resp_valid), 0);
        run(1'b0, 4'd5, 8'h00, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run(1'b0, AW'(k), 8'h00, 0, 1'b1);
            if (k > 0) check("b2b_gap", 32'(acc_cyc - prev_acc), 4);
            prev_acc = acc_cyc;
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        for (int n = 0; n < 30; n++)
            run(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 3)), 1'b0);
`ifdef MEMORY_CONTROLLER_STATS_EN
        check("wr_count", 32'(wr_count), 32'(wr_exp));
        check("rd_count", 32'(rd_count), 32'(rd_exp));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
